// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and op latency.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  // Multiplies and divides occupy the unit; moves and no-ops do not.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic int unsigned mdu_latency(input logic [2:0] op,
                                              input int unsigned mult_cycles,
                                              input int unsigned div_cycles);
    return ((op == MDU_MULT) || (op == MDU_MULTU)) ? mult_cycles : div_cycles;
  endfunction

endpackage

// File: rtl/mdu_core_calc.sv
// Combinational product/quotient/remainder for MULT/MULTU/DIV/DIVU, including the
// MIPS divide-by-zero and MIN_INT/-1 overflow results.
module mdu_core_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic signed [2*WIDTH-1:0] sa_x, sb_x, sprod;
  logic        [2*WIDTH-1:0] uprod;
  logic signed [WIDTH-1:0]   sa, sdiv_b, squot, srem;
  logic        [WIDTH-1:0]   udiv_b, uquot, urem;
  logic                      div_zero, div_ovf;

  assign sa_x  = {{WIDTH{a[WIDTH-1]}}, a};
  assign sb_x  = {{WIDTH{b[WIDTH-1]}}, b};
  assign sprod = sa_x * sb_x;
  assign uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign div_zero = (b == '0);
  assign div_ovf  = (a == MIN_INT) && (b == ALL_ONES);

  // Special-case divisors are swapped for 1 so the dividers never see /0 or overflow.
  assign sa     = $signed(a);
  assign sdiv_b = (div_zero || div_ovf) ? $signed(ONE) : $signed(b);
  assign udiv_b = div_zero ? ONE : b;
  assign squot  = sa / sdiv_b;
  assign srem   = sa % sdiv_b;
  assign uquot  = a / udiv_b;
  assign urem   = a % udiv_b;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      MDU_MULT: begin
        res_hi = sprod[2*WIDTH-1:WIDTH];
        res_lo = sprod[WIDTH-1:0];
      end
      MDU_MULTU: begin
        res_hi = uprod[2*WIDTH-1:WIDTH];
        res_lo = uprod[WIDTH-1:0];
      end
      MDU_DIV: begin
        if (div_zero) begin
          res_hi = a;
          res_lo = ALL_ONES;
        end else if (div_ovf) begin
          res_hi = '0;
          res_lo = MIN_INT;
        end else begin
          res_hi = srem;
          res_lo = squot;
        end
      end
      MDU_DIVU: begin
        if (div_zero) begin
          res_hi = a;
          res_lo = ALL_ONES;
        end else begin
          res_hi = urem;
          res_lo = uquot;
        end
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// Define MDU_CANCEL_EN to let the cancel input abort an in-flight operation.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             launch, commit, wr_hi, wr_lo, cancel_act;
  logic [WIDTH-1:0] calc_hi, calc_lo, pend_hi, pend_lo;

`ifdef MDU_CANCEL_EN
  assign cancel_act = cancel;
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_act    = 1'b0;
`endif

  mdu_core_calc #(.WIDTH(WIDTH)) u_calc (
    .op    (op),
    .a     (a),
    .b     (b),
    .res_hi(calc_hi),
    .res_lo(calc_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    launch    = 1'b0;
    commit    = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !cancel_act) begin
          if (is_long_op(op)) begin
            launch    = 1'b1;
            cnt_nxt   = CNT_W'(mdu_latency(op, MULT_CYCLES, DIV_CYCLES));
            state_nxt = BUSY;
          end else begin
            wr_hi = (op == MDU_MTHI);
            wr_lo = (op == MDU_MTLO);
          end
        end
      end
      BUSY: begin
        // Cancel outranks the commit edge; start is never looked at here.
        if (cancel_act) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt == CNT_W'(1)) begin
          commit    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      done <= 1'b0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      cnt  <= cnt_nxt;
      done <= commit;
      if (commit) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end else begin
        if (wr_hi) hi <= a;
        if (wr_lo) lo <= a;
      end
    end
  end

  // Result is captured at launch so a/b may change while busy; reset never commits it.
  always_ff @(posedge clk) begin
    if (launch) begin
      pend_hi <= calc_hi;
      pend_lo <= calc_lo;
    end
  end

  assign busy = (state == BUSY);

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed vector table, randomized ops against
// a 64-bit arithmetic reference model, and hand-written busy/reset/cancel sequences.
module tb_mdu_unit;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          cancel = 1'b0;
  logic [2:0]    op = 3'd6;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    string       name;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  mdu_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic plus the MIPS special cases.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                inout logic [31:0] h, inout logic [31:0] l);
    longint sx, sy, q, r;
    longint unsigned ux, uy;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = ux * uy; h = p[63:32]; l = p[31:0]; end
      3'd2: begin
        if (y == 0) begin l = 32'hFFFF_FFFF; h = x; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin l = 32'h8000_0000; h = 0; end
        else begin q = sx / sy; r = sx % sy; p = q; l = p[31:0]; p = r; h = p[31:0]; end
      end
      3'd3: begin
        if (y == 0) begin l = 32'hFFFF_FFFF; h = x; end
        else begin l = x / y; h = x % y; end
      end
      3'd4: h = x;
      3'd5: l = x;
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'd6; a = $urandom; b = $urandom;
  endtask

  task automatic finish_wait(input int n0, input int ncyc, input logic [31:0] ehi,
                             input logic [31:0] elo, input string tag);
    int n;
    bit hold_ok;
    n = n0;
    hold_ok = 1'b1;
    while (busy && n < 60) begin
      if (hi !== m_hi || lo !== m_lo || done !== 1'b0) hold_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, n, ncyc);
    check({tag, " hold"}, 32'(hold_ok), 32'd1);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " hi"}, hi, ehi);
    check({tag, " lo"}, lo, elo);
    m_hi = ehi;
    m_lo = elo;
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo, input string tag);
    issue(o, x, y);
    if (o <= 3'd3) begin
      finish_wait(0, (o <= 3'd1) ? MC : DC, ehi, elo, tag);
    end else begin
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " done"}, 32'(done), 32'd0);
      check({tag, " hi"}, hi, ehi);
      check({tag, " lo"}, lo, elo);
      m_hi = ehi;
      m_lo = elo;
    end
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry, eh, el;
    int          sel;

    vecs[0]  = '{3'd0, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg"};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, "multu"};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg"};
    vecs[3]  = '{3'd3, 32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF, "divu_zero"};
    vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf"};
    vecs[5]  = '{3'd4, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'h8000_0000, "mthi"};
    vecs[6]  = '{3'd5, 32'h0000_0055, 32'd9,        32'h0000_1234, 32'h0000_0055, "mtlo"};
    vecs[7]  = '{3'd6, 32'hDEAD_BEEF, 32'd3,        32'h0000_1234, 32'h0000_0055, "nop6"};
    vecs[8]  = '{3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, "mult_max"};
    vecs[9]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_negdiv"};
    vecs[10] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, "divu"};
    vecs[11] = '{3'd2, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_zero"};

    #1 reset = 1'b0;
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].name);

    // Start of MTLO while a MULT is in flight must be dropped.
    eh = m_hi; el = m_lo;
    model(3'd0, 32'h0001_0003, 32'hFFFF_0002, eh, el);
    issue(3'd0, 32'h0001_0003, 32'hFFFF_0002);
    @(negedge clk);
    op = 3'd5; a = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'd6;
    finish_wait(2, MC, eh, el, "busy_start_ignored");

    // Asynchronous reset in the middle of a MULT.
    issue(3'd0, 32'd1234, 32'd5678);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset hi", hi, 32'd0);
    check("midreset lo", lo, 32'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) check("midreset no_done", {30'd0, busy, done}, 32'd0);
    end
    check("midreset quiet", {30'd0, busy, done}, 32'd0);

    // Cancel at cycle 4 of a DIV.
    eh = m_hi; el = m_lo;
    model(3'd2, 32'd100, 32'd7, eh, el);
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
`ifdef MDU_CANCEL_EN
    check("cancel busy", 32'(busy), 32'd0);
    check("cancel done", 32'(done), 32'd0);
    check("cancel hi", hi, m_hi);
    check("cancel lo", lo, m_lo);
    @(negedge clk);
    check("cancel no_done", 32'(done), 32'd0);
    op = 3'd4; a = 32'hCAFE_0000; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = 3'd6;
    check("cancel_start hi", hi, m_hi);
    check("cancel_start busy", 32'(busy), 32'd0);
`else
    finish_wait(4, DC, eh, el, "cancel_ignored");
`endif

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) ry = 0;
      if (sel == 1) begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
      if (sel == 2) ry = 32'($urandom_range(1, 9));
      eh = m_hi; el = m_lo;
      model(ro, rx, ry, eh, el);
      run_op(ro, rx, ry, eh, el, $sformatf("rand%0d_op%0d", i, ro));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
